// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// ALU operand/op select codes, compare-flag bit positions and the control bundle.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ST_FETCH     = 4'd0;
   localparam logic [3:0] ST_DECODE    = 4'd1;
   localparam logic [3:0] ST_EX_ALU    = 4'd2;
   localparam logic [3:0] ST_LUI       = 4'd3;
   localparam logic [3:0] ST_WB_ALU    = 4'd4;
   localparam logic [3:0] ST_WB_MEM    = 4'd5;
   localparam logic [3:0] ST_EX_ADDR   = 4'd6;
   localparam logic [3:0] ST_MEM_RD    = 4'd7;
   localparam logic [3:0] ST_MEM_WR    = 4'd8;
   localparam logic [3:0] ST_BRANCH    = 4'd9;
   localparam logic [3:0] ST_PC_INC    = 4'd10;
   localparam logic [3:0] ST_JAL       = 4'd11;
   localparam logic [3:0] ST_JALR_ADDR = 4'd12;
   localparam logic [3:0] ST_JALR_JUMP = 4'd13;
   localparam logic [3:0] ST_WB_LINK   = 4'd14;
   localparam logic [3:0] ST_TRAP      = 4'd15;

   localparam logic [1:0] A_PC    = 2'd0;
   localparam logic [1:0] A_RS1   = 2'd1;
   localparam logic [1:0] A_ZERO  = 2'd2;
   localparam logic [1:0] B_RS2   = 2'd0;
   localparam logic [1:0] B_FOUR  = 2'd1;
   localparam logic [1:0] B_IMM   = 2'd2;
   localparam logic [1:0] SUB_ADD = 2'd0;
   localparam logic [1:0] SUB_SUB = 2'd1;
   localparam logic [1:0] SUB_I30 = 2'd2;

   localparam int CMP_EQ  = 0;
   localparam int CMP_LT  = 1;
   localparam int CMP_LTU = 2;

   typedef struct packed {
      logic       pc_write;
      logic       s_pc;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic [1:0] alu_a;
      logic [1:0] alu_b;
      logic       alu_f3;
      logic [1:0] alu_sub;
      logic       retire;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, enables/selects out.
interface multicycle_ctrl_if;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       inst30;
   logic [2:0] compare;
   logic       mem_ready;
   logic       pc_write;
   logic       s_pc;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       mem_to_reg;
   logic [1:0] alu_a_sel;
   logic [1:0] alu_b_sel;
   logic       alu_f3_sel;
   logic [1:0] alu_sub_sel;
   logic       retire;
   logic       illegal;
   logic       bus_err;

   modport master (
      input  opcode, func3, inst30, compare, mem_ready,
      output pc_write, s_pc, iord, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
             alu_a_sel, alu_b_sel, alu_f3_sel, alu_sub_sel, retire, illegal, bus_err
   );

   modport slave (
      output opcode, func3, inst30, compare, mem_ready,
      input  pc_write, s_pc, iord, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
             alu_a_sel, alu_b_sel, alu_f3_sel, alu_sub_sel, retire, illegal, bus_err
   );
endinterface

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch resolution from func3 and ALU compare flags; 010/011 are not branches.
module multicycle_ctrl_branch_cond
   import multicycle_ctrl_pkg::*;
(
   input  logic [2:0] func3_i,
   input  logic [2:0] compare_i,
   output logic       taken_o,
   output logic       bad_func3_o
);
   logic cond;

   always_comb begin
      cond = 1'b0;
      case (func3_i[2:1])
         2'b00:   cond = compare_i[CMP_EQ];
         2'b10:   cond = compare_i[CMP_LT];
         2'b11:   cond = compare_i[CMP_LTU];
         default: cond = 1'b0;
      endcase
   end

   assign bad_func3_o = (func3_i[2:1] == 2'b01);
   assign taken_o     = ~bad_func3_o & (cond ^ func3_i[0]);
endmodule

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/write-back
// and drives every datapath enable and mux select, one instruction at a time.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 0,
   parameter int unsigned CNT_W       = 8
) (
   input logic               clk_i,
   input logic               clr_i,
   multicycle_ctrl_if.master bus
);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic             taken, bad_func3, mem_wait, timeout;
   ctrl_t            c;

   multicycle_ctrl_branch_cond u_branch_cond (
      .func3_i     (bus.func3),
      .compare_i   (bus.compare),
      .taken_o     (taken),
      .bad_func3_o (bad_func3)
   );

   assign mem_wait = ((state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR))
                     && !bus.mem_ready;
   assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == TMO_LAST);

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (bus.opcode)
               OPC_OP, OPC_OPIMM:    state_d = ST_EX_ALU;
               OPC_LUI:              state_d = ST_LUI;
               OPC_AUIPC:            state_d = ST_WB_ALU;
               OPC_LOAD, OPC_STORE:  state_d = ST_EX_ADDR;
               OPC_BRANCH:           state_d = ST_BRANCH;
               OPC_JAL:              state_d = ST_JAL;
               OPC_JALR:             state_d = ST_JALR_ADDR;
               default: begin
                  state_d   = ST_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_EX_ALU, ST_LUI: state_d = ST_WB_ALU;
         ST_WB_ALU, ST_WB_MEM, ST_PC_INC, ST_WB_LINK: state_d = ST_FETCH;
         ST_EX_ADDR: state_d = (bus.opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:  if (bus.mem_ready) state_d = ST_WB_MEM;
         ST_MEM_WR:  if (bus.mem_ready) state_d = ST_FETCH;
         ST_BRANCH: begin
            if (bad_func3) begin
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = taken ? ST_FETCH : ST_PC_INC;
            end
         end
         ST_JAL, ST_JALR_JUMP: state_d = ST_WB_LINK;
         ST_JALR_ADDR:         state_d = ST_JALR_JUMP;
         default:              state_d = ST_TRAP;
      endcase
      if (timeout) begin
         state_d   = ST_TRAP;
         bus_err_d = 1'b1;
      end
   end

   // Counter restarts on every state change so each memory access gets its own budget.
   assign wait_d = (state_d != state_q) ? '0 : (mem_wait ? wait_q + 1'b1 : wait_q);

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q   <= ST_FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      c = '0;
      case (state_q)
         ST_FETCH: begin
            c.mem_read = 1'b1;
            c.ir_write = bus.mem_ready;
         end
         ST_DECODE: c.alu_b = B_IMM;
         ST_EX_ALU: begin
            c.alu_a  = A_RS1;
            c.alu_b  = (bus.opcode == OPC_OP) ? B_RS2 : B_IMM;
            c.alu_f3 = 1'b1;
            if ((bus.opcode == OPC_OP) || (bus.func3 == 3'b101)) c.alu_sub = SUB_I30;
         end
         ST_LUI: begin
            c.alu_a = A_ZERO;
            c.alu_b = B_IMM;
         end
         ST_WB_ALU, ST_WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = (state_q == ST_WB_MEM);
            c.pc_write   = 1'b1;
            c.alu_a      = A_PC;
            c.alu_b      = B_FOUR;
            c.retire     = 1'b1;
         end
         ST_EX_ADDR, ST_JALR_ADDR: begin
            c.alu_a = A_RS1;
            c.alu_b = B_IMM;
         end
         ST_MEM_RD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         ST_MEM_WR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
            if (bus.mem_ready) begin
               c.pc_write = 1'b1;
               c.alu_b    = B_FOUR;
               c.retire   = 1'b1;
            end
         end
         ST_BRANCH: begin
            c.alu_a   = A_RS1;
            c.alu_b   = B_RS2;
            c.alu_sub = SUB_SUB;
            if (taken) begin
               c.pc_write = 1'b1;
               c.s_pc     = 1'b1;
               c.retire   = 1'b1;
            end
         end
         ST_PC_INC: begin
            c.pc_write = 1'b1;
            c.alu_b    = B_FOUR;
            c.retire   = 1'b1;
         end
         ST_JAL, ST_JALR_JUMP: begin
            c.pc_write = 1'b1;
            c.s_pc     = 1'b1;
            c.alu_b    = B_FOUR;
         end
         ST_WB_LINK: begin
            c.reg_write = 1'b1;
            c.retire    = 1'b1;
         end
         default: c = '0;
      endcase
   end

   assign bus.pc_write    = c.pc_write  & ~clr_i;
   assign bus.s_pc        = c.s_pc;
   assign bus.iord        = c.iord;
   assign bus.mem_read    = c.mem_read;
   assign bus.mem_write   = c.mem_write & ~clr_i;
   assign bus.ir_write    = c.ir_write  & ~clr_i;
   assign bus.reg_write   = c.reg_write & ~clr_i;
   assign bus.mem_to_reg  = c.mem_to_reg;
   assign bus.alu_a_sel   = c.alu_a;
   assign bus.alu_b_sel   = c.alu_b;
   assign bus.alu_f3_sel  = c.alu_f3;
   assign bus.alu_sub_sel = c.alu_sub;
   assign bus.retire      = c.retire    & ~clr_i;
   assign bus.illegal     = illegal_q;
   assign bus.bus_err     = bus_err_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction into its
// expected per-cycle control words, which are then replayed against the DUT cycle by cycle.
module tb_multicycle_ctrl;
   localparam int TMO = 4;

   localparam logic [6:0] L_OP = 7'b0110011, L_OPIMM = 7'b0010011, L_LUI = 7'b0110111,
                          L_AUIPC = 7'b0010111, L_LOAD = 7'b0000011, L_STORE = 7'b0100011,
                          L_BR = 7'b1100011, L_JAL = 7'b1101111, L_JALR = 7'b1100111;

   typedef struct packed {
      logic        mr;
      logic        clr;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        i30;
      logic [2:0]  cmp;
      logic [15:0] w;
      logic        ill;
      logic        berr;
   } step_t;

   logic clk = 1'b0;
   logic clr;
   multicycle_ctrl_if bus_if ();

   multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk_i (clk),
      .clr_i (clr),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   step_t       q[$];
   step_t       s;
   logic [15:0] obs;
   logic [6:0]  g_op;
   logic [2:0]  g_f3, g_cmp;
   logic        g_i30;
   logic        cur_ill, cur_berr;
   int          ncmp = 0;
   int          nfail = 0;

   // Control word layout: pcw s_pc iord mrd mwr irw rw m2r a[2] b[2] f3 sub[2] retire
   function automatic logic [15:0] cw(bit pcw, bit spc, bit iord, bit mrd, bit mwr, bit irw,
                                      bit rw, bit m2r, int a, int b, bit f3s, int sub, bit ret);
      return {pcw, spc, iord, mrd, mwr, irw, rw, m2r, 2'(a), 2'(b), f3s, 2'(sub), ret};
   endfunction

   function automatic bit is_legal(logic [6:0] op);
      return op inside {L_OP, L_OPIMM, L_LUI, L_AUIPC, L_LOAD, L_STORE, L_BR, L_JAL, L_JALR};
   endfunction

   task automatic push(input logic mr, input logic c, input logic [15:0] w);
      step_t e;
      e.mr = mr; e.clr = c; e.op = g_op; e.f3 = g_f3; e.i30 = g_i30; e.cmp = g_cmp;
      e.w = w; e.ill = cur_ill; e.berr = cur_berr;
      q.push_back(e);
   endtask

   // Two idle cycles in TRAP, then clr back to FETCH with flags cleared.
   task automatic trap_tail();
      push(1'($urandom), 1'b0, 16'h0);
      push(1'($urandom), 1'b0, 16'h0);
      push(1'($urandom), 1'b1, 16'h0);
      cur_ill  = 1'b0;
      cur_berr = 1'b0;
   endtask

   // n waiting cycles then one accepted cycle; n >= TMO means the access times out.
   task automatic mem_phase(input logic [15:0] wait_w, input logic [15:0] done_w, input int n,
                            output bit ok);
      if (n >= TMO) begin
         repeat (TMO) push(1'b0, 1'b0, wait_w);
         cur_berr = 1'b1;
         ok = 1'b0;
      end else begin
         repeat (n) push(1'b0, 1'b0, wait_w);
         push(1'b1, 1'b0, done_w);
         ok = 1'b1;
      end
   endtask

   task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic i30,
                            input logic [2:0] cmp, input int wf, input int wm);
      bit ok, tk;
      logic [15:0] pc4_wb, link;
      g_op = op; g_f3 = f3; g_i30 = i30; g_cmp = cmp;
      pc4_wb = cw(1,0,0,0,0,0,1,0, 0,1,0,0,1);
      link   = cw(0,0,0,0,0,0,1,0, 0,0,0,0,1);
      mem_phase(cw(0,0,0,1,0,0,0,0, 0,0,0,0,0), cw(0,0,0,1,0,1,0,0, 0,0,0,0,0), wf, ok);
      if (!ok) begin trap_tail(); return; end
      push(1'($urandom), 1'b0, cw(0,0,0,0,0,0,0,0, 0,2,0,0,0));
      case (op)
         L_OP: begin
            push(1'($urandom), 1'b0, cw(0,0,0,0,0,0,0,0, 1,0,1,2,0));
            push(1'($urandom), 1'b0, pc4_wb);
         end
         L_OPIMM: begin
            push(1'($urandom), 1'b0, cw(0,0,0,0,0,0,0,0, 1,2,1,(f3 == 3'b101) ? 2 : 0,0));
            push(1'($urandom), 1'b0, pc4_wb);
         end
         L_LUI: begin
            push(1'($urandom), 1'b0, cw(0,0,0,0,0,0,0,0, 2,2,0,0,0));
            push(1'($urandom), 1'b0, pc4_wb);
         end
         L_AUIPC: push(1'($urandom), 1'b0, pc4_wb);
         L_LOAD: begin
            push(1'($urandom), 1'b0, cw(0,0,0,0,0,0,0,0, 1,2,0,0,0));
            mem_phase(cw(0,0,1,1,0,0,0,0, 0,0,0,0,0), cw(0,0,1,1,0,0,0,0, 0,0,0,0,0), wm, ok);
            if (!ok) trap_tail();
            else push(1'($urandom), 1'b0, cw(1,0,0,0,0,0,1,1, 0,1,0,0,1));
         end
         L_STORE: begin
            push(1'($urandom), 1'b0, cw(0,0,0,0,0,0,0,0, 1,2,0,0,0));
            mem_phase(cw(0,0,1,0,1,0,0,0, 0,0,0,0,0), cw(1,0,1,0,1,0,0,0, 0,1,0,0,1), wm, ok);
            if (!ok) trap_tail();
         end
         L_BR: begin
            case (f3)
               3'b000:  tk = cmp[0];
               3'b001:  tk = !cmp[0];
               3'b100:  tk = cmp[1];
               3'b101:  tk = !cmp[1];
               3'b110:  tk = cmp[2];
               3'b111:  tk = !cmp[2];
               default: tk = 1'b0;
            endcase
            push(1'($urandom), 1'b0, cw(tk,tk,0,0,0,0,0,0, 1,0,0,1,tk));
            if (f3 == 3'b010 || f3 == 3'b011) begin
               cur_ill = 1'b1;
               trap_tail();
            end else if (!tk) begin
               push(1'($urandom), 1'b0, cw(1,0,0,0,0,0,0,0, 0,1,0,0,1));
            end
         end
         L_JAL: begin
            push(1'($urandom), 1'b0, cw(1,1,0,0,0,0,0,0, 0,1,0,0,0));
            push(1'($urandom), 1'b0, link);
         end
         L_JALR: begin
            push(1'($urandom), 1'b0, cw(0,0,0,0,0,0,0,0, 1,2,0,0,0));
            push(1'($urandom), 1'b0, cw(1,1,0,0,0,0,0,0, 0,1,0,0,0));
            push(1'($urandom), 1'b0, link);
         end
         default: begin
            cur_ill = 1'b1;
            trap_tail();
         end
      endcase
   endtask

   function automatic int rand_wait();
      return ($urandom_range(0, 11) == 0) ? TMO : int'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [6:0] op;
      cur_ill = 1'b0; cur_berr = 1'b0;
      g_op = 7'h0; g_f3 = 3'h0; g_i30 = 1'b0; g_cmp = 3'h0;

      // Reset state: FETCH with memory not yet ready.
      push(1'b0, 1'b0, cw(0,0,0,1,0,0,0,0, 0,0,0,0,0));
      gen_instr(L_OP,    3'b000, 1'b0, 3'b000, 0, 0);
      gen_instr(L_OPIMM, 3'b000, 1'b1, 3'b000, 0, 0);
      gen_instr(L_OPIMM, 3'b101, 1'b1, 3'b000, 0, 0);
      gen_instr(L_BR,    3'b001, 1'b0, 3'b001, 0, 0);
      gen_instr(L_BR,    3'b001, 1'b0, 3'b000, 0, 0);
      gen_instr(L_LOAD,  3'b010, 1'b0, 3'b000, 0, 3);
      gen_instr(L_STORE, 3'b010, 1'b0, 3'b000, 1, 2);
      gen_instr(L_OP,    3'b000, 1'b0, 3'b000, TMO, 0);
      gen_instr(7'h7F,   3'b000, 1'b0, 3'b000, 0, 0);
      gen_instr(L_BR,    3'b010, 1'b0, 3'b000, 0, 0);
      gen_instr(L_JAL,   3'b000, 1'b0, 3'b000, 0, 0);
      gen_instr(L_JALR,  3'b000, 1'b0, 3'b000, 0, 0);
      gen_instr(L_LUI,   3'b000, 1'b0, 3'b000, 0, 0);
      gen_instr(L_AUIPC, 3'b000, 1'b0, 3'b000, 0, 0);
      gen_instr(L_LOAD,  3'b000, 1'b0, 3'b000, 0, TMO);

      // clr in the JAL cycle: the jump write is suppressed and FETCH restarts.
      g_op = L_JAL;
      push(1'b1, 1'b0, cw(0,0,0,1,0,1,0,0, 0,0,0,0,0));
      push(1'b0, 1'b0, cw(0,0,0,0,0,0,0,0, 0,2,0,0,0));
      push(1'b0, 1'b1, cw(0,1,0,0,0,0,0,0, 0,1,0,0,0));
      // clr while FETCH sees mem_ready: no IR latch.
      push(1'b1, 1'b1, cw(0,0,0,1,0,0,0,0, 0,0,0,0,0));
      gen_instr(L_OP,    3'b111, 1'b1, 3'b000, 0, 0);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0: op = L_OP;     1: op = L_OPIMM; 2: op = L_LUI;  3: op = L_AUIPC;
            4: op = L_LOAD;   5: op = L_STORE; 6: op = L_BR;   7: op = L_JAL;
            8: op = L_JALR;
            default: begin
               do op = 7'($urandom); while (is_legal(op));
            end
         endcase
         gen_instr(op, 3'($urandom), 1'($urandom), 3'($urandom), rand_wait(), rand_wait());
      end

      clr = 1'b1;
      bus_if.mem_ready = 1'b0; bus_if.opcode = 7'h0; bus_if.func3 = 3'h0;
      bus_if.inst30 = 1'b0; bus_if.compare = 3'h0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < q.size(); i++) begin
         s = q[i];
         @(negedge clk);
         clr = s.clr;
         bus_if.mem_ready = s.mr;
         bus_if.opcode = s.op;
         bus_if.func3 = s.f3;
         bus_if.inst30 = s.i30;
         bus_if.compare = s.cmp;
         #1;
         obs = {bus_if.pc_write, bus_if.s_pc, bus_if.iord, bus_if.mem_read, bus_if.mem_write,
                bus_if.ir_write, bus_if.reg_write, bus_if.mem_to_reg, bus_if.alu_a_sel,
                bus_if.alu_b_sel, bus_if.alu_f3_sel, bus_if.alu_sub_sel, bus_if.retire};
         ncmp++;
         assert (obs === s.w) else begin
            nfail++;
            $error("FAIL ctrl_word step=%0d op=%b observed=%h expected=%h", i, s.op, obs, s.w);
         end
         ncmp++;
         assert ({bus_if.illegal, bus_if.bus_err} === {s.ill, s.berr}) else begin
            nfail++;
            $error("FAIL flags step=%0d observed ill/berr=%b%b expected=%b%b", i,
                   bus_if.illegal, bus_if.bus_err, s.ill, s.berr);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
